// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to
// instruction memory, buffers returned words in a 2-entry FIFO and presents
// one instruction per cycle to register fetch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no outstanding memory request
// BUSY  | request outstanding, returned data will be buffered
// DROP  | request outstanding, returned data will be discarded (redirected)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              stall_i,
  if_stage_if.master        imem,
  output logic [31:0]       ins_o,
  output logic [31:0]       pc_o,
  output logic              ins_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] fifo_pc_q  [2];
  logic [31:0] fifo_ins_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d, count_after;
  logic [31:0] ins_q, pc_q;
  logic        valid_q;
  logic        push, pop;
  logic        req;
  logic [31:0] redirect_tgt;
  logic        unused_pc_bits;

  // Fetch is word aligned; the low target bits are dropped.
  assign redirect_tgt   = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // An ack only carries a usable word in BUSY without a simultaneous redirect.
  assign push = (state_q == S_BUSY) && imem.imem_ack_i && !redirect_i;
  assign pop  = !redirect_i && !stall_i && (count_q != 2'd0);

  // FIFO occupancy after this cycle's push/pop (BUSY never holds count 2).
  always_comb begin
    count_after = count_q + {1'b0, push} - {1'b0, pop};
    count_d     = redirect_i ? 2'd0 : count_after;
    fetch_pc_d  = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_i && (count_q != 2'd2)) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (imem.imem_ack_i) begin
          if (redirect_i || (count_after == 2'd2)) begin
            state_d = S_IDLE;
          end
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem.imem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request strobe and the address to hold for the next request.
  always_comb begin
    req        = (state_q == S_BUSY) || (state_q == S_DROP);
    req_addr_d = req_addr_q;
    if (state_d == S_BUSY) begin
      req_addr_d = fetch_pc_d;
    end
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = req_addr_q;

  // Fetch PC and registered request address.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Two-entry {pc, ins} FIFO; a redirect empties it.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      fifo_pc_q[0]  <= RESET_PC;
      fifo_pc_q[1]  <= RESET_PC;
      fifo_ins_q[0] <= NOP_INS;
      fifo_ins_q[1] <= NOP_INS;
    end else begin
      count_q <= count_d;
      if (redirect_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc_q[wr_ptr_q]  <= fetch_pc_q;
          fifo_ins_q[wr_ptr_q] <= imem.imem_data_i;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // Output registers towards register fetch; redirect beats stall.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ins_q   <= NOP_INS;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (count_q != 2'd0) begin
        ins_q   <= fifo_ins_q[rd_ptr_q];
        pc_q    <= fifo_pc_q[rd_ptr_q];
        valid_q <= 1'b1;
      end else begin
        ins_q   <= NOP_INS;
        valid_q <= 1'b0;
      end
    end
  end

  assign ins_o       = ins_q;
  assign pc_o        = pc_q;
  assign ins_valid_o = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based model of the fetch stage.
module tb_if_stage;
  localparam logic [31:0] K      = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] ins_o, pc_o;
  logic        ins_valid_o;

  int tests = 0;
  int fails = 0;

  if_stage_if imem();

  if_stage #(.RESET_PC(RST_PC), .NOP_INS(NOP)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem          (imem),
    .ins_o         (ins_o),
    .pc_o          (pc_o),
    .ins_valid_o   (ins_valid_o)
  );

  always #5 clk = ~clk;

  // Reference model: buffered words in a queue, plus whether a memory
  // request is outstanding and whether its answer is to be thrown away.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t      m_q[$];
  bit          m_out, m_discard, m_valid;
  logic [31:0] m_fpc, m_addr, m_ins, m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = 1'b0; m_discard = 1'b0;
    m_fpc = RST_PC; m_addr = RST_PC;
    m_ins = NOP; m_pc = RST_PC; m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit r, input logic [31:0] rpc, input bit s,
                            input bit a, input logic [31:0] d);
    bit take;
    int n_before;
    entry_t e;
    n_before = m_q.size();
    take = m_out && !m_discard && a && !r;
    if (r) begin
      m_ins = NOP; m_valid = 1'b0;
    end else if (!s) begin
      if (n_before > 0) begin
        e = m_q.pop_front();
        m_pc = e.pc; m_ins = e.ins; m_valid = 1'b1;
      end else begin
        m_ins = NOP; m_valid = 1'b0;
      end
    end
    if (r) begin
      m_q.delete();
    end else if (take) begin
      e.pc = m_fpc; e.ins = d;
      m_q.push_back(e);
    end
    if (r) m_fpc = {rpc[31:2], 2'b00};
    else if (take) m_fpc = m_fpc + 32'd4;
    if (m_out) begin
      if (a) begin
        if (take && m_q.size() < 2) m_addr = m_fpc;
        else begin m_out = 1'b0; m_discard = 1'b0; end
      end else if (r) begin
        m_discard = 1'b1;
      end
    end else if (!r && n_before < 2) begin
      m_out = 1'b1; m_addr = m_fpc;
    end
  endtask

  task automatic check_all();
    chk("req", {31'b0, imem.imem_req_o}, {31'b0, m_out});
    if (m_out) chk("addr", imem.imem_addr_o, m_addr);
    chk("ins", ins_o, m_ins);
    chk("pc", pc_o, m_pc);
    chk("valid", {31'b0, ins_valid_o}, {31'b0, m_valid});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   {31'b0, imem.imem_req_o}, 32'd0);
    chk({tag, "_addr"},  imem.imem_addr_o, RST_PC);
    chk({tag, "_ins"},   ins_o, NOP);
    chk({tag, "_pc"},    pc_o, RST_PC);
    chk({tag, "_valid"}, {31'b0, ins_valid_o}, 32'd0);
  endtask

  // One clock: drive inputs, take the edge, advance model, compare.
  task automatic cyc(input bit r, input logic [31:0] rpc, input bit s, input bit a);
    logic [31:0] d;
    d = a ? (imem.imem_addr_o ^ K) : $urandom;
    redirect_i = r; redirect_pc_i = rpc; stall_i = s;
    imem.imem_ack_i = a; imem.imem_data_i = d;
    @(posedge clk);
    model_edge(r, rpc, s, a, d);
    #1;
    check_all();
  endtask

  // Called at posedge+1: reset held across one edge, released between edges.
  task automatic apply_reset();
    rst_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0; imem.imem_ack_i = 1'b0;
    #1;
    model_reset();
    check_reset("rst");
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] frozen_pc, exp_pc;
    logic [31:0] seen[$];
    bit found;

    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    imem.imem_ack_i = 1'b0; imem.imem_data_i = '0;
    #12;
    model_reset();
    check_reset("por");
    @(posedge clk); #1;
    rst_i = 1'b1;

    // Streaming: first valid output three edges after release.
    cyc(0, 0, 0, 1);
    chk("first_req", {31'b0, imem.imem_req_o}, 32'd1);
    chk("first_valid_e1", {31'b0, ins_valid_o}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("first_valid_e2", {31'b0, ins_valid_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      chk("stream_pc", pc_o, 32'(i * 4));
      chk("stream_valid", {31'b0, ins_valid_o}, 32'd1);
      chk("stream_ins", ins_o, 32'(i * 4) ^ K);
    end

    // Stall for six cycles: outputs frozen, FIFO fills, request drops.
    frozen_pc = pc_o;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 1);
      chk("stall_frozen", pc_o, frozen_pc);
    end
    chk("stall_req_low", {31'b0, imem.imem_req_o}, 32'd0);
    exp_pc = frozen_pc + 32'd4;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      if (ins_valid_o) begin
        chk("stall_contig", pc_o, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end

    // Redirect while the request at 0x10 waits for its ack.
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem.imem_req_o && imem.imem_addr_o == 32'h10) found = 1'b1;
      else cyc(0, 0, 0, 1);
    end
    chk("reach_0x10", {31'b0, found}, 32'd1);
    cyc(1, 32'h0000_0103, 0, 0);
    chk("drop_addr_held", imem.imem_addr_o, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("drop_addr_held2", imem.imem_addr_o, 32'h10);
    cyc(0, 0, 0, 1);
    chk("drop_req_low", {31'b0, imem.imem_req_o}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("drop_next_addr", imem.imem_addr_o, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ins_valid_o) found = 1'b1;
      else cyc(0, 0, 0, 1);
    end
    chk("drop_target_seen", {31'b0, found}, 32'd1);
    chk("drop_target_pc", pc_o, 32'h100);
    chk("drop_target_ins", ins_o, 32'h100 ^ K);

    // Redirect coincident with an ack.
    cyc(0, 0, 0, 1);
    cyc(1, 32'h0000_0200, 0, 1);
    chk("ackredir_req_low", {31'b0, imem.imem_req_o}, 32'd0);
    chk("ackredir_valid", {31'b0, ins_valid_o}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("ackredir_req", {31'b0, imem.imem_req_o}, 32'd1);
    chk("ackredir_addr", imem.imem_addr_o, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ins_valid_o) found = 1'b1;
      else cyc(0, 0, 0, 1);
    end
    chk("ackredir_seen", {31'b0, found}, 32'd1);
    chk("ackredir_pc", pc_o, 32'h200);

    // Wrap at the top of the address space.
    cyc(1, 32'hFFFF_FFFC, 0, 1);
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1);
      if (ins_valid_o) seen.push_back(pc_o);
    end
    chk("wrap_count_ok", {31'b0, seen.size() >= 2}, 32'd1);
    if (seen.size() >= 2) begin
      chk("wrap_first", seen[0], 32'hFFFF_FFFC);
      chk("wrap_second", seen[1], 32'h0000_0000);
    end

    // Asynchronous reset between edges mid-stream.
    #3;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_reset("async");
    imem.imem_ack_i = 1'b0;
    @(posedge clk); #1;
    check_reset("async_hold");
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("restart_pc", pc_o, RST_PC);
    chk("restart_valid", {31'b0, ins_valid_o}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      bit r, s, a;
      logic [31:0] rpc;
      r = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cyc(r, rpc, s, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
